lcd_pcf8574_ctrl: RTL and testbench

LCD_PCF8574_CTRL -- requirements
Module: lcd_pcf8574_ctrl

---
 rtl/lcd_pcf8574_ctrl_pkg.sv | 62 ++++++
 rtl/lcd_delay_timer.sv | 28 ++
 rtl/lcd_pcf8574_ctrl.sv | 164 ++++++++++++++++
 tb/tb_lcd_pcf8574_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pcf8574_ctrl_pkg.sv
// Shared types and constants for the HD44780-over-PCF8574 LCD controller:
// FSM state encoding, expander bit map, delay counter width and init ROM.
package lcd_pcf8574_ctrl_pkg;

  typedef enum logic [2:0] {
    PWRUP    = 3'd0,
    INIT     = 3'd1,
    IDLE     = 3'd2,
    SEND     = 3'd3,
    WAIT_I2C = 3'd4,
    DELAY    = 3'd5,
    ERROR    = 3'd6
  } state_t;

  // Expander bit positions: P7..P4 carry LCD D7..D4
  localparam int BIT_RS   = 0;
  localparam int BIT_RW   = 1;
  localparam int BIT_EN   = 2;
  localparam int BIT_BL   = 3;
  localparam int DATA_LSB = 4;

  // Wide enough for the 250_000 and 2_500_000 cycle waits
  localparam int TIMER_W  = 22;
  localparam int INIT_OPS = 8;

  // One init step: opcode (nibble ops use opcode[3:0]), width flag, delay select
  typedef struct packed {
    logic [7:0] opcode;
    logic       is_byte;
    logic       delay_long;
  } init_op_t;

  // 4-bit mode wake-up, function set, display on, entry mode, clear
  function automatic init_op_t init_rom(input logic [2:0] idx);
    init_op_t op;
    case (idx)
      3'd0:    op = '{opcode: 8'h03, is_byte: 1'b0, delay_long: 1'b1};
      3'd1:    op = '{opcode: 8'h03, is_byte: 1'b0, delay_long: 1'b0};
      3'd2:    op = '{opcode: 8'h03, is_byte: 1'b0, delay_long: 1'b0};
      3'd3:    op = '{opcode: 8'h02, is_byte: 1'b0, delay_long: 1'b0};
      3'd4:    op = '{opcode: 8'h28, is_byte: 1'b1, delay_long: 1'b0};
      3'd5:    op = '{opcode: 8'h0C, is_byte: 1'b1, delay_long: 1'b0};
      3'd6:    op = '{opcode: 8'h06, is_byte: 1'b1, delay_long: 1'b0};
      default: op = '{opcode: 8'h01, is_byte: 1'b1, delay_long: 1'b1};
    endcase
    return op;
  endfunction

  // Assemble one expander byte; RW is always 0 (write only)
  function automatic logic [7:0] make_frame(input logic [3:0] nib, input logic bl,
                                            input logic en, input logic rs);
    logic [7:0] f;
    f                    = '0;
    f[DATA_LSB +: 4]     = nib;
    f[BIT_BL]            = bl;
    f[BIT_EN]            = en;
    f[BIT_RW]            = 1'b0;
    f[BIT_RS]            = rs;
    return f;
  endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Up-counting wait timer shared by the power-up wait and the settle delays.
// After load (or reset) expired rises once 'value' cycles have been spent
// counting, then the count parks so it can never wrap.
module lcd_delay_timer
  import lcd_pcf8574_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [TIMER_W-1:0] value,
  output logic               expired
);

  logic [TIMER_W-1:0] cnt;

  // Expired on the last cycle of the wait, so a wait of N occupies N cycles
  assign expired = ({1'b0, cnt} + {{TIMER_W{1'b0}}, 1'b1}) >= {1'b0, value};

  // Count from zero after load/reset, hold once expired
  always_ff @(posedge clk) begin
    if (rst || load) begin
      cnt <= '0;
    end else if (!expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/lcd_pcf8574_ctrl.sv
// HD44780 LCD controller driving a PCF8574 I2C backpack in 4-bit mode.
// Runs the power-up init sequence, then accepts one command or character at
// a time and emits the EN-strobed expander frames to an I2C byte master.
//
// Handshakes: a client command transfers on a cycle where cmd_valid and
// cmd_ready are both high; rs/data are captured that cycle and cmd_valid is
// otherwise ignored (no queueing). Towards the byte master i2c_req is raised
// with i2c_byte and both hold steady until a one-cycle i2c_done (or i2c_nack)
// pulse; i2c_req drops the cycle after, so each frame is a fresh request.
module lcd_pcf8574_ctrl
  import lcd_pcf8574_ctrl_pkg::*;
#(
  parameter int unsigned POWERUP_CYCLES = 2_500_000,
  parameter int unsigned DELAY_SHORT    = 2_500,
  parameter int unsigned DELAY_LONG     = 250_000,
  parameter logic [6:0]  I2C_ADDR       = 7'h27,
  parameter logic        BACKLIGHT      = 1'b1
)
(
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic       cmd_rs,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  output logic       i2c_req,
  output logic [6:0] i2c_addr,
  output logic [7:0] i2c_byte,
  input  logic       i2c_done,
  input  logic       i2c_nack,
  output logic       init_done,
  output logic       error,
  output state_t     state_dbg
);

  localparam logic [TIMER_W-1:0] PWR_V   = TIMER_W'(POWERUP_CYCLES);
  localparam logic [TIMER_W-1:0] SHORT_V = TIMER_W'(DELAY_SHORT);
  localparam logic [TIMER_W-1:0] LONG_V  = TIMER_W'(DELAY_LONG);

  state_t       state;
  logic [2:0]   op_idx;
  logic [1:0]   frame_idx;
  logic [7:0]   op_data;
  logic         op_is_byte;
  logic         op_rs;
  logic         op_long;

  init_op_t     rom_op;
  logic [3:0]   cur_nib;
  logic [7:0]   cur_frame;
  logic         last_frame;
  logic         tmr_load;
  logic [TIMER_W-1:0] tmr_value;
  logic         tmr_expired;

  assign i2c_addr  = I2C_ADDR;
  assign cmd_ready = (state == IDLE) && init_done && !error;
  assign state_dbg = state;
  assign rom_op    = init_rom(op_idx);

  // Frame contents: even frames have EN high, odd frames EN low; a byte
  // sends its high nibble in frames 0/1 and its low nibble in frames 2/3
  always_comb begin
    cur_nib    = op_is_byte ? (frame_idx[1] ? op_data[3:0] : op_data[7:4]) : op_data[3:0];
    cur_frame  = make_frame(cur_nib, BACKLIGHT, ~frame_idx[0], op_rs);
    last_frame = op_is_byte ? (frame_idx == 2'd3) : (frame_idx == 2'd1);
  end

  // The timer restarts as the last frame of an operation completes
  assign tmr_load  = (state == WAIT_I2C) && i2c_done && !i2c_nack && last_frame;
  assign tmr_value = (state == PWRUP) ? PWR_V : (op_long ? LONG_V : SHORT_V);

  lcd_delay_timer u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .value   (tmr_value),
    .expired (tmr_expired)
  );

  // Main controller FSM with registered bus outputs and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= PWRUP;
      op_idx     <= '0;
      frame_idx  <= '0;
      op_data    <= '0;
      op_is_byte <= 1'b0;
      op_rs      <= 1'b0;
      op_long    <= 1'b0;
      i2c_req    <= 1'b0;
      i2c_byte   <= '0;
      init_done  <= 1'b0;
      error      <= 1'b0;
    end else begin
      case (state)
        PWRUP: begin
          if (tmr_expired) begin
            op_idx <= '0;
            state  <= INIT;
          end
        end
        INIT: begin
          op_data    <= rom_op.opcode;
          op_is_byte <= rom_op.is_byte;
          op_long    <= rom_op.delay_long;
          op_rs      <= 1'b0;
          frame_idx  <= '0;
          state      <= SEND;
        end
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            op_data    <= cmd_data;
            op_rs      <= cmd_rs;
            op_is_byte <= 1'b1;
            // Clear and home need the long settle time
            op_long    <= !cmd_rs && ((cmd_data == 8'h01) || (cmd_data == 8'h02));
            frame_idx  <= '0;
            state      <= SEND;
          end
        end
        SEND: begin
          i2c_req  <= 1'b1;
          i2c_byte <= cur_frame;
          state    <= WAIT_I2C;
        end
        WAIT_I2C: begin
          if (i2c_nack) begin
            i2c_req <= 1'b0;
            error   <= 1'b1;
            state   <= ERROR;
          end else if (i2c_done) begin
            i2c_req <= 1'b0;
            if (last_frame) begin
              state <= DELAY;
            end else begin
              frame_idx <= frame_idx + 2'd1;
              state     <= SEND;
            end
          end
        end
        DELAY: begin
          if (tmr_expired) begin
            if (init_done) begin
              state <= IDLE;
            end else if (op_idx == 3'(INIT_OPS - 1)) begin
              init_done <= 1'b1;
              state     <= IDLE;
            end else begin
              op_idx <= op_idx + 3'd1;
              state  <= INIT;
            end
          end
        end
        ERROR: begin
          i2c_req <= 1'b0;
          error   <= 1'b1;
        end
        default: state <= PWRUP;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_pcf8574_ctrl.sv
// Self-checking bench for lcd_pcf8574_ctrl: an I2C byte-master responder,
// a frame monitor against an expected-frame queue built from the LCD
// protocol rules, directed scenarios and randomized commands.
module tb_lcd_pcf8574_ctrl;
  import lcd_pcf8574_ctrl_pkg::*;

  localparam int PWR   = 10;
  localparam int SHORT = 3;
  localparam int LONG  = 6;
  // One cycle to fetch the first init step, one to present its frame
  localparam int FIRST_REQ_LAT = PWR + 2;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_rs;
  logic [7:0] cmd_data;
  logic       cmd_ready;
  logic       i2c_req;
  logic [6:0] i2c_addr;
  logic [7:0] i2c_byte;
  logic       i2c_done;
  logic       i2c_nack;
  logic       init_done;
  logic       error;
  state_t     state_dbg;

  lcd_pcf8574_ctrl #(
    .POWERUP_CYCLES (PWR),
    .DELAY_SHORT    (SHORT),
    .DELAY_LONG     (LONG),
    .I2C_ADDR       (7'h27),
    .BACKLIGHT      (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_rs    (cmd_rs),
    .cmd_data  (cmd_data),
    .cmd_ready (cmd_ready),
    .i2c_req   (i2c_req),
    .i2c_addr  (i2c_addr),
    .i2c_byte  (i2c_byte),
    .i2c_done  (i2c_done),
    .i2c_nack  (i2c_nack),
    .init_done (init_done),
    .error     (error),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset / cycle count ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int checks = 0;
  int passes = 0;
  int frame_cnt = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, got, want, $time);
  endtask

  // Expected expander frames for one operation, straight from the LCD rules:
  // each nibble goes out as {nib,BL=1,EN=1,RW=0,RS} then the same with EN=0
  function automatic void push_op(input int val, input bit is_byte, input bit rs);
    int nibs[2];
    int n;
    if (is_byte) begin
      nibs[0] = (val / 16) % 16;
      nibs[1] = val % 16;
      n = 2;
    end else begin
      nibs[0] = val % 16;
      nibs[1] = 0;
      n = 1;
    end
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(8'(nibs[i] * 16 + 8 + 4 + int'(rs)));
      exp_q.push_back(8'(nibs[i] * 16 + 8 + int'(rs)));
    end
  endfunction

  function automatic void push_init();
    int vals[8];
    vals = '{3, 3, 3, 2, 'h28, 'h0C, 'h06, 'h01};
    for (int i = 0; i < 8; i++) push_op(vals[i], i >= 4, 1'b0);
  endfunction

  function automatic int exp_delay(input bit rs, input int data);
    return (!rs && (data == 1 || data == 2)) ? LONG : SHORT;
  endfunction

  // ---------------- I2C byte-master responder ----------------
  int  nack_frame = 0;
  bit  nack_only  = 1'b0;
  int  done_edge  = 0;
  int  nack_edge  = 0;

  initial begin
    bit busy;
    int wcnt;
    int resp_frame;
    busy = 1'b0; wcnt = 0; resp_frame = 0;
    i2c_done = 1'b0;
    i2c_nack = 1'b0;
    forever begin
      @(posedge clk); #1;
      i2c_done = 1'b0;
      i2c_nack = 1'b0;
      if (rst) begin
        busy = 1'b0;
        resp_frame = 0;
      end else if (busy) begin
        wcnt++;
        if (wcnt == 2) begin
          busy = 1'b0;
          resp_frame++;
          if (resp_frame == nack_frame) begin
            i2c_nack  = 1'b1;
            i2c_done  = !nack_only;
            nack_edge = cyc + 1;
          end else begin
            i2c_done  = 1'b1;
            done_edge = cyc + 1;
          end
        end
      end else if (i2c_req) begin
        busy = 1'b1;
        wcnt = 0;
      end
    end
  end

  // ---------------- per-cycle frame monitor ----------------
  initial begin
    logic       prev_req;
    logic [7:0] held;
    prev_req = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (i2c_req && !prev_req) begin
        check("i2c_addr", 32'(i2c_addr), 32'h27);
        check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("frame_value", 32'(i2c_byte), 32'(exp_q.pop_front()));
        got_q.push_back(i2c_byte);
        held = i2c_byte;
        frame_cnt++;
      end else if (i2c_req && prev_req) begin
        check("byte_stable", 32'(i2c_byte), 32'(held));
      end
      prev_req = i2c_req;
    end
  end

  // ---------------- driver tasks ----------------
  int rst_edge = 0;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    got_q.delete();
    frame_cnt = 0;
    @(negedge clk);
    check("rst_req_next_cycle", 32'(i2c_req), 32'd0);
    @(negedge clk);
    check("rst_req",       32'(i2c_req),   32'd0);
    check("rst_byte",      32'(i2c_byte),  32'h00);
    check("rst_ready",     32'(cmd_ready), 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_error",     32'(error),     32'd0);
    check("rst_state",     32'(state_dbg), 32'(PWRUP));
    rst_edge = cyc;
    rst = 1'b0;
  endtask

  task automatic wait_first_req();
    int n;
    n = 0;
    while (!i2c_req && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("first_req_latency", 32'(cyc - rst_edge), 32'(FIRST_REQ_LAT));
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!cmd_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_ready_seen"}, 32'(cmd_ready), 32'd1);
  endtask

  task automatic check_init(input string name);
    wait_ready(name);
    check({name, "_init_done"}, 32'(init_done), 32'd1);
    check({name, "_frames"}, 32'(frame_cnt), 32'd24);
    check({name, "_delay"}, 32'(cyc - done_edge), 32'(LONG));
  endtask

  // Issue one command (controller must be ready) and check its whole effect
  task automatic send_cmd(input bit rs, input logic [7:0] data);
    push_op(int'(data), 1'b1, rs);
    cmd_rs    = rs;
    cmd_data  = data;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("cmd_accepted", 32'(cmd_ready), 32'd0);
    wait_ready("cmd");
    check("cmd_delay", 32'(cyc - done_edge), 32'(exp_delay(rs, int'(data))));
    check("cmd_frames_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int base;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_rs = 1'b0;
    cmd_data = 8'h00;

    // Init sequence, with a character command held valid throughout
    do_reset();
    push_init();
    push_op('h41, 1'b1, 1'b1);
    cmd_rs = 1'b1;
    cmd_data = 8'h41;
    cmd_valid = 1'b1;
    wait_first_req();
    check_init("init");
    check("init_lit0",  32'(got_q[0]),  32'h3C);
    check("init_lit1",  32'(got_q[1]),  32'h38);
    check("init_lit20", 32'(got_q[20]), 32'h0C);
    check("init_lit21", 32'(got_q[21]), 32'h08);
    check("init_lit22", 32'(got_q[22]), 32'h1C);
    check("init_lit23", 32'(got_q[23]), 32'h18);
    // Held command goes in on the first idle cycle
    @(negedge clk);
    cmd_valid = 1'b0;
    check("held_cmd_accepted", 32'(cmd_ready), 32'd0);
    wait_ready("cmd41");
    check("cmd41_delay", 32'(cyc - done_edge), 32'(SHORT));
    check("cmd41_lit0", 32'(got_q[24]), 32'h4D);
    check("cmd41_lit1", 32'(got_q[25]), 32'h49);
    check("cmd41_lit2", 32'(got_q[26]), 32'h1D);
    check("cmd41_lit3", 32'(got_q[27]), 32'h19);
    check("cmd41_count", 32'(frame_cnt), 32'd28);

    // Clear display: long delay
    base = got_q.size();
    send_cmd(1'b0, 8'h01);
    check("clr_lit0", 32'(got_q[base]),     32'h0C);
    check("clr_lit1", 32'(got_q[base + 1]), 32'h08);
    check("clr_lit2", 32'(got_q[base + 2]), 32'h1C);
    check("clr_lit3", 32'(got_q[base + 3]), 32'h18);

    // Boundaries: home (long), same codes as data (short)
    send_cmd(1'b0, 8'h02);
    send_cmd(1'b1, 8'h01);
    send_cmd(1'b1, 8'h02);
    send_cmd(1'b0, 8'h03);

    // Randomized commands
    for (int i = 0; i < 16; i++) begin
      bit rs;
      logic [7:0] d;
      rs = 1'($urandom_range(0, 1));
      d  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 2)) : 8'($urandom_range(0, 255));
      send_cmd(rs, d);
    end

    // Reset while a frame is outstanding, then a full re-init
    push_op('h55, 1'b1, 1'b1);
    cmd_rs = 1'b1;
    cmd_data = 8'h55;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    begin
      int n;
      n = 0;
      while (!i2c_req && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    check("midframe_req_high", 32'(i2c_req), 32'd1);
    do_reset();
    push_init();
    wait_first_req();
    check_init("reinit");

    // NACK together with done on the 3rd init frame
    nack_frame = 3;
    nack_only = 1'b0;
    do_reset();
    push_init();
    begin
      int n;
      n = 0;
      while (!error && n < 500) begin
        @(negedge clk);
        n++;
      end
    end
    check("nack_error",      32'(error),           32'd1);
    check("nack_next_cycle", 32'(cyc - nack_edge), 32'd0);
    check("nack_req_low",    32'(i2c_req),         32'd0);
    check("nack_state",      32'(state_dbg),       32'(ERROR));
    check("nack_frames",     32'(frame_cnt),       32'd3);
    cmd_rs = 1'b1;
    cmd_data = 8'h41;
    cmd_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      check("err_ready_low", 32'(cmd_ready), 32'd0);
      check("err_sticky",    32'(error),     32'd1);
    end
    cmd_valid = 1'b0;
    check("err_no_more_frames", 32'(frame_cnt), 32'd3);

    // NACK without done on the 6th init frame
    nack_frame = 6;
    nack_only = 1'b1;
    do_reset();
    push_init();
    begin
      int n;
      n = 0;
      while (!error && n < 500) begin
        @(negedge clk);
        n++;
      end
    end
    check("nack2_error",      32'(error),           32'd1);
    check("nack2_next_cycle", 32'(cyc - nack_edge), 32'd0);
    check("nack2_req_low",    32'(i2c_req),         32'd0);
    repeat (10) @(negedge clk);
    check("nack2_frames",     32'(frame_cnt),       32'd6);
    check("nack2_ready_low",  32'(cmd_ready),       32'd0);
    nack_frame = 0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
